// File: rtl/seq_det_arbiter.sv
// Round-robin sharing of one serial pattern detector among NUM_REQ bit streams.
// Each grant opens a window of up to FRAME_LEN bits; matches are tagged and counted per requester.
module seq_det_arbiter #(
  parameter int                NUM_REQ   = 4,
  parameter int                PAT_W     = 12,
  parameter logic [PAT_W-1:0]  PATTERN   = 12'b1110_1101_1011,
  parameter int                FRAME_LEN = 32,
  parameter int                CNT_W     = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [NUM_REQ-1:0]         bit_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic                       busy_o,
  output logic                       det_o,
  output logic [$clog2(NUM_REQ)-1:0] det_id_o,
  output logic                       frame_done_o,
  output logic                       abort_o,
  output logic [NUM_REQ*CNT_W-1:0]   match_cnt_o
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam int BC_W = $clog2(FRAME_LEN + 1);
  localparam int VC_W = $clog2(PAT_W + 1);
  localparam logic [BC_W-1:0]    FRAME_LAST = BC_W'(FRAME_LEN);
  localparam logic [VC_W-1:0]    VALID_FULL = VC_W'(PAT_W);
  localparam logic [ID_W-1:0]    LAST_ID    = ID_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0   = NUM_REQ'(1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_t;

  state_t                        state_q, state_d;
  logic [ID_W-1:0]               gid_q, gid_d;
  logic [ID_W-1:0]               rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]               det_id_q, det_id_d;
  logic [PAT_W-1:0]              hist_q, hist_d;
  logic [BC_W-1:0]               bit_cnt_q, bit_cnt_d;
  logic [VC_W-1:0]               valid_cnt_q, valid_cnt_d;
  logic [NUM_REQ-1:0]            gnt_q, gnt_d;
  logic                          det_q, det_d;
  logic                          frame_done_q, frame_done_d;
  logic                          abort_q, abort_d;
  logic [NUM_REQ-1:0][CNT_W-1:0] cnt_q, cnt_d;

  logic [ID_W-1:0] idx_s;
  logic [ID_W-1:0] pick_s;
  logic            pick_vld_s;
  logic [ID_W-1:0] gid_next_s;
  logic            match_s;

  // Cyclic search for the first requester at or after rr_ptr.
  always_comb begin
    idx_s      = '0;
    pick_s     = '0;
    pick_vld_s = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx_s = ID_W'((int'(rr_ptr_q) + i) % NUM_REQ);
      if (!pick_vld_s && req_i[idx_s]) begin
        pick_s     = idx_s;
        pick_vld_s = 1'b1;
      end else begin
        pick_s     = pick_s;
        pick_vld_s = pick_vld_s;
      end
    end
  end

  assign gid_next_s = (gid_q == LAST_ID) ? '0 : gid_q + ID_W'(1);

  // Next-state and output computation for the IDLE/SERVE sequencer.
  always_comb begin
    state_d      = state_q;
    gid_d        = gid_q;
    rr_ptr_d     = rr_ptr_q;
    hist_d       = hist_q;
    bit_cnt_d    = bit_cnt_q;
    valid_cnt_d  = valid_cnt_q;
    gnt_d        = gnt_q;
    det_d        = 1'b0;
    det_id_d     = det_id_q;
    frame_done_d = 1'b0;
    abort_d      = 1'b0;
    cnt_d        = cnt_q;
    match_s      = 1'b0;
    case (state_q)
      IDLE: begin
        // History is wiped here so a pattern can never straddle two windows.
        hist_d      = '0;
        bit_cnt_d   = '0;
        valid_cnt_d = '0;
        if (pick_vld_s) begin
          gid_d   = pick_s;
          gnt_d   = ONE_HOT0 << pick_s;
          state_d = SERVE;
        end else begin
          gnt_d   = '0;
          state_d = IDLE;
        end
      end
      SERVE: begin
        if (req_i[gid_q]) begin
          hist_d      = {hist_q[PAT_W-2:0], bit_i[gid_q]};
          bit_cnt_d   = bit_cnt_q + BC_W'(1);
          valid_cnt_d = (valid_cnt_q == VALID_FULL) ? valid_cnt_q : valid_cnt_q + VC_W'(1);
          match_s     = (valid_cnt_d == VALID_FULL) && (hist_d == PATTERN);
          if (match_s) begin
            det_d    = 1'b1;
            det_id_d = gid_q;
            cnt_d[gid_q] = (&cnt_q[gid_q]) ? cnt_q[gid_q] : cnt_q[gid_q] + CNT_W'(1);
          end else begin
            det_d    = 1'b0;
            det_id_d = det_id_q;
          end
          if (bit_cnt_d == FRAME_LAST) begin
            frame_done_d = 1'b1;
            rr_ptr_d     = gid_next_s;
            gnt_d        = '0;
            state_d      = IDLE;
          end else begin
            frame_done_d = 1'b0;
            state_d      = SERVE;
          end
        end else begin
          abort_d  = 1'b1;
          rr_ptr_d = gid_next_s;
          gnt_d    = '0;
          state_d  = IDLE;
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      gid_q        <= '0;
      rr_ptr_q     <= '0;
      det_id_q     <= '0;
      hist_q       <= '0;
      bit_cnt_q    <= '0;
      valid_cnt_q  <= '0;
      gnt_q        <= '0;
      det_q        <= 1'b0;
      frame_done_q <= 1'b0;
      abort_q      <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      gid_q        <= gid_d;
      rr_ptr_q     <= rr_ptr_d;
      det_id_q     <= det_id_d;
      hist_q       <= hist_d;
      bit_cnt_q    <= bit_cnt_d;
      valid_cnt_q  <= valid_cnt_d;
      gnt_q        <= gnt_d;
      det_q        <= det_d;
      frame_done_q <= frame_done_d;
      abort_q      <= abort_d;
      cnt_q        <= cnt_d;
    end
  end

  assign gnt_o        = gnt_q;
  assign busy_o       = |gnt_q;
  assign det_o        = det_q;
  assign det_id_o     = det_id_q;
  assign frame_done_o = frame_done_q;
  assign abort_o      = abort_q;
  assign match_cnt_o  = cnt_q;

endmodule

// File: tb/tb_seq_det_arbiter.sv
// Scoreboard bench for seq_det_arbiter: directed windows push expected det/frame_done/abort
// events with their cycle; a negedge monitor pops and compares whenever the DUT pulses.
module tb_seq_det_arbiter;

  localparam int         NUM_REQ   = 4;
  localparam int         PAT_W     = 12;
  localparam int         FRAME_LEN = 32;
  localparam int         CNT_W     = 8;
  localparam logic [11:0] PAT      = 12'b1110_1101_1011;

  logic        clk;
  logic        reset;
  logic [3:0]  req_i;
  logic [3:0]  bit_i;
  logic [3:0]  gnt_o;
  logic        busy_o;
  logic        det_o;
  logic [1:0]  det_id_o;
  logic        frame_done_o;
  logic        abort_o;
  logic [31:0] match_cnt_o;

  seq_det_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .PAT_W    (PAT_W),
    .PATTERN  (PAT),
    .FRAME_LEN(FRAME_LEN),
    .CNT_W    (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_i       (req_i),
    .bit_i       (bit_i),
    .gnt_o       (gnt_o),
    .busy_o      (busy_o),
    .det_o       (det_o),
    .det_id_o    (det_id_o),
    .frame_done_o(frame_done_o),
    .abort_o     (abort_o),
    .match_cnt_o (match_cnt_o)
  );

  typedef struct {
    int cyc;
    int id;
  } ev_t;

  ev_t exp_det[$];
  int  exp_fd[$];
  int  exp_ab[$];
  ev_t m_e;
  int  cyc    = 0;
  int  n_cmp  = 0;
  int  n_fail = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every DUT pulse must match the oldest expectation of its kind, on the expected cycle.
  always @(negedge clk) begin
    if (det_o) begin
      if (exp_det.size() == 0) chk("det_spurious", 64'd1, 64'd0);
      else begin
        m_e = exp_det.pop_front();
        chk("det_cycle", cyc, m_e.cyc);
        chk("det_id", det_id_o, m_e.id);
      end
    end else if (exp_det.size() != 0 && exp_det[0].cyc <= cyc) begin
      m_e = exp_det.pop_front();
      chk("det_missing_at_cycle", 64'd0, m_e.cyc);
    end
    if (frame_done_o) begin
      if (exp_fd.size() == 0) chk("frame_done_spurious", 64'd1, 64'd0);
      else chk("frame_done_cycle", cyc, exp_fd.pop_front());
    end else if (exp_fd.size() != 0 && exp_fd[0] <= cyc) begin
      chk("frame_done_missing_at_cycle", 64'd0, exp_fd.pop_front());
    end
    if (abort_o) begin
      chk("abort_exclusive", {frame_done_o, det_o}, 64'd0);
      if (exp_ab.size() == 0) chk("abort_spurious", 64'd1, 64'd0);
      else chk("abort_cycle", cyc, exp_ab.pop_front());
    end else if (exp_ab.size() != 0 && exp_ab[0] <= cyc) begin
      chk("abort_missing_at_cycle", 64'd0, exp_ab.pop_front());
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_gnt"}, gnt_o, 64'd0);
    chk({tag, "_busy"}, busy_o, 64'd0);
    chk({tag, "_det"}, det_o, 64'd0);
    chk({tag, "_det_id"}, det_id_o, 64'd0);
    chk({tag, "_frame_done"}, frame_done_o, 64'd0);
    chk({tag, "_abort"}, abort_o, 64'd0);
    chk({tag, "_match_cnt"}, match_cnt_o, 64'd0);
  endtask

  // Called in IDLE just after a clock edge; one edge later the grant must be visible.
  task automatic start_grant(input logic [3:0] req, input int id);
    logic [3:0] oh;
    oh = 4'b0001 << id;
    chk("gnt_idle", gnt_o, 64'd0);
    chk("busy_idle", busy_o, 64'd0);
    req_i = req;
    @(posedge clk);
    #1;
    chk("gnt_start", gnt_o, oh);
    chk("busy_serve", busy_o, 64'd1);
  endtask

  // Stream n bits (seq[0] first) to requester id; dm[k] marks bits that complete a match.
  task automatic send_bits(input int id, input logic [0:63] seq, input logic [0:63] dm, input int n);
    logic [3:0] oh;
    oh = 4'b0001 << id;
    for (int k = 0; k < n; k++) begin
      chk("gnt_window", gnt_o, oh);
      bit_i     = 4'b0000;
      bit_i[id] = seq[k];
      if (dm[k]) exp_det.push_back('{cyc + 1, id});
      if (k == n - 1 && n == FRAME_LEN) exp_fd.push_back(cyc + 1);
      @(posedge clk);
      #1;
    end
    bit_i = 4'b0000;
  endtask

  initial begin
    logic [0:63] s;
    logic [0:63] d;
    int          exp3;
    reset = 1'b1;
    req_i = 4'b0000;
    bit_i = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_all_zero("reset");

    // Round robin with requesters 0 and 2 held: 0, 2, 0, 2.
    for (int w = 0; w < 4; w++) begin
      start_grant(4'b0101, (w % 2 == 0) ? 0 : 2);
      send_bits((w % 2 == 0) ? 0 : 2, 64'd0, 64'd0, 32);
    end

    // Single match on requester 0.
    s = {PAT, 52'b0};
    d = 64'd0;
    d[11] = 1'b1;
    start_grant(4'b0001, 0);
    send_bits(0, s, d, 32);
    chk("cnt0_single", match_cnt_o[7:0], 64'd1);

    // Overlapping matches, 10 bits apart.
    s = {PAT, 10'b1011011011, 42'b0};
    d = 64'd0;
    d[11] = 1'b1;
    d[21] = 1'b1;
    start_grant(4'b0001, 0);
    send_bits(0, s, d, 32);
    chk("cnt0_overlap", match_cnt_o[7:0], 64'd3);

    // Pattern split across two windows never matches.
    s = {26'b0, 6'b111011, 32'b0};
    start_grant(4'b0001, 0);
    send_bits(0, s, 64'd0, 32);
    s = {6'b011011, 58'b0};
    start_grant(4'b0001, 0);
    send_bits(0, s, 64'd0, 32);
    chk("cnt0_split", match_cnt_o[7:0], 64'd3);

    // Abort on requester 1 after 5 bits; requester 2 is next.
    start_grant(4'b0110, 1);
    send_bits(1, {5'b10111, 59'b0}, 64'd0, 5);
    req_i = 4'b0100;
    exp_ab.push_back(cyc + 1);
    @(posedge clk);
    #1;
    chk("gnt_after_abort", gnt_o, 64'd0);
    start_grant(4'b0100, 2);
    send_bits(2, 64'd0, 64'd0, 32);
    chk("cnt1_after_abort", match_cnt_o[15:8], 64'd0);

    // Three matches per window on requester 3 (last one coincides with frame_done) until saturation.
    s = {2'b11, 10'b1011011011, 10'b1011011011, 10'b1011011011, 32'b0};
    d = 64'd0;
    d[11] = 1'b1;
    d[21] = 1'b1;
    d[31] = 1'b1;
    for (int w = 1; w <= 87; w++) begin
      start_grant(4'b1000, 3);
      send_bits(3, s, d, 32);
      exp3 = (3 * w > 255) ? 255 : 3 * w;
      chk("cnt3_sat", match_cnt_o[31:24], exp3);
    end
    chk("cnt0_untouched", match_cnt_o[7:0], 64'd3);

    // Move rr_ptr to 2, open a window on 3, then reset just before the matching bit.
    start_grant(4'b0010, 1);
    send_bits(1, 64'd0, 64'd0, 5);
    req_i = 4'b0000;
    exp_ab.push_back(cyc + 1);
    @(posedge clk);
    #1;
    start_grant(4'b1001, 3);
    send_bits(3, {PAT, 52'b0}, 64'd0, 11);
    bit_i[3] = 1'b1;
    reset    = 1'b1;
    #1;
    check_all_zero("mid_reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    bit_i = 4'b0000;
    start_grant(4'b1001, 0);
    send_bits(0, 64'd0, 64'd0, 32);

    req_i = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    chk("det_queue_drained", exp_det.size(), 64'd0);
    chk("frame_done_queue_drained", exp_fd.size(), 64'd0);
    chk("abort_queue_drained", exp_ab.size(), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
